// File: rtl/intersection_arbiter.sv
// Round-robin green grant across N_WAYS approaches with an all-red clearance between greens; grant two cycles after a request.
// 'blocked' holds off new greens only at grant decisions; optional GREEN_EXTEND_EN keeps an uncontested green running.
module intersection_arbiter #(
   parameter int N_WAYS       = 4,
   parameter int GREEN_PERIOD = 10000,
   parameter int CLEAR_PERIOD = 200
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_WAYS-1:0] request,
   input  logic              blocked,
   output logic [N_WAYS-1:0] green,
   output logic [N_WAYS-1:0] red,
   output logic [N_WAYS-1:0] pending,
   output logic              busy
);

   localparam int IW = $clog2(N_WAYS);

   typedef enum logic [1:0] {IDLE, GREEN, CLEAR} state_t;

   state_t            state, state_nx;
   logic [31:0]       count, count_nx;
   logic [IW-1:0]     sel, sel_nx;
   logic [IW-1:0]     ptr, ptr_nx;
   logic [N_WAYS-1:0] clr;
   logic [N_WAYS-1:0] rot;
   logic [N_WAYS-1:0] sel_oh;
   logic [N_WAYS-1:0] win_oh;
   logic [IW-1:0]     off;
   logic [IW:0]       sum;
   logic [IW:0]       wsum;
   logic [IW-1:0]     winner;
   logic [IW-1:0]     ptr_after;
   logic              found;

   // Rotate pending so bit 0 is the way at ptr; first set bit is the circular winner.
   assign rot = N_WAYS'({pending, pending} >> ptr);

   always_comb begin
      off   = '0;
      found = 1'b0;
      for (int j = 0; j < N_WAYS; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            off   = IW'(j);
         end
      end
   end

   assign sum       = {1'b0, ptr} + {1'b0, off};
   assign winner    = (sum >= (IW+1)'(N_WAYS)) ? IW'(sum - (IW+1)'(N_WAYS)) : sum[IW-1:0];
   assign wsum      = {1'b0, winner} + (IW+1)'(1);
   assign ptr_after = (wsum == (IW+1)'(N_WAYS)) ? '0 : wsum[IW-1:0];
   assign win_oh    = N_WAYS'(1) << winner;
   assign sel_oh    = N_WAYS'(1) << sel;

   always_comb begin
      state_nx = state;
      count_nx = count;
      sel_nx   = sel;
      ptr_nx   = ptr;
      clr      = '0;
      case (state)
         IDLE: begin
            if (found && !blocked) begin
               state_nx = GREEN;
               count_nx = 32'(GREEN_PERIOD - 1);
               sel_nx   = winner;
               ptr_nx   = ptr_after;
               clr      = win_oh;
            end
         end
         GREEN: begin
            if (count != 32'd0) begin
               count_nx = count - 32'd1;
            end else
`ifdef GREEN_EXTEND_EN
            // Nobody else is waiting: keep the same way green without clearance.
            if ((pending[sel] || request[sel]) && ((pending & ~sel_oh) == '0)) begin
               count_nx = 32'(GREEN_PERIOD - 1);
               clr      = sel_oh;
            end else
`endif
            begin
               state_nx = CLEAR;
               count_nx = 32'(CLEAR_PERIOD - 1);
            end
         end
         CLEAR: begin
            if (count != 32'd0) begin
               count_nx = count - 32'd1;
            end else if (!found) begin
               state_nx = IDLE;
            end else if (!blocked) begin
               state_nx = GREEN;
               count_nx = 32'(GREEN_PERIOD - 1);
               sel_nx   = winner;
               ptr_nx   = ptr_after;
               clr      = win_oh;
            end
         end
         default: begin
            state_nx = IDLE;
            count_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         sel     <= '0;
         ptr     <= '0;
         pending <= '0;
      end else begin
         state   <= state_nx;
         count   <= count_nx;
         sel     <= sel_nx;
         ptr     <= ptr_nx;
         pending <= (pending | request) & ~clr;
      end
   end

   assign green = (state == GREEN) ? sel_oh : '0;
   assign red   = ~green;
   assign busy  = (state != IDLE);

endmodule

// File: doc/intersection_arbiter.md
# intersection_arbiter

Shares one road crossing between `N_WAYS` approaches, each driving a single light. Collects per-way requests, grants green to exactly one way at a time in round-robin order, and inserts an all-red clearance interval between consecutive greens. It sits above the per-approach light logic and is the only block that decides which way may enter the crossing.

## Interface
- `N_WAYS`, 4, number of approaches; legal range 2..16.
- `GREEN_PERIOD`, 10000, green duration in cycles; must be ≥ 1.
- `CLEAR_PERIOD`, 200, all-red clearance duration in cycles; must be ≥ 1.

- Reset: `reset` is synchronous and active-high. Clock: `clock`.
- `clock`  input  1  system clock.
- `reset`  input  1  synchronous, active-high reset.
- `request`  input  N_WAYS  per-way request, level or pulse; sampled every cycle.
- `blocked`  input  1  crossing occupied or obstructed; inhibits starting a new green.
- `green`  output  N_WAYS  one-hot or zero; bit i means way i has green.
- `red`  output  N_WAYS  equals `~green`.
- `pending`  output  N_WAYS  latched, not-yet-served requests.
- `busy`  output  1  high when state is not IDLE.

## Operation
- Internal state:
  - FSM with states IDLE, GREEN and CLEAR.
  - 32-bit down-counter.
  - `sel`: index of the current green way.
  - Round-robin pointer `ptr`.
- Pending update every cycle: `pending <= (pending | request) & ~clr`.
  - `clr` is the one-hot of the way granted this edge.
  - Clear wins over a same-cycle request.
- Winner: the first set bit of `pending` at or after `ptr`, searching circularly upward. On each grant, `ptr <= (winner+1) mod N_WAYS`.
- IDLE:
  - All outputs red.
  - If `pending != 0` and `!blocked`: grant the winner, go to GREEN, load counter with `GREEN_PERIOD-1`.
  - Otherwise stay in IDLE.
- GREEN:
  - `green[sel]=1`.
  - While counter > 0, decrement.
  - At counter == 0: go to CLEAR, load counter with `CLEAR_PERIOD-1`.
  - `blocked` is ignored in GREEN.
- CLEAR:
  - All outputs red.
  - While counter > 0, decrement.
  - At counter == 0 with `pending == 0`: go to IDLE.
  - At counter == 0 with `pending != 0` and `!blocked`: grant the winner, go to GREEN, load counter with `GREEN_PERIOD-1`.
  - At counter == 0 with `pending != 0` and `blocked`: hold in CLEAR at 0.
- Invariant: at most one bit of `green` is ever set. A change of green way always passes through at least `CLEAR_PERIOD` all-red cycles.

## Timing
- Reset values, effective on the edge after `reset` is high:
  - state IDLE, `green=0`, `red` all ones.
  - `pending=0`, `busy=0`, `ptr=0`, counter 0, `sel=0`.
- Reset mid-GREEN drops green on that same edge. No clearance interval is generated.
- Request latency:
  - A `request[i]` high in cycle k sets `pending[i]` in cycle k+1.
  - If the FSM is IDLE and not blocked, `green[i]` is high from cycle k+2.
- Green lasts exactly `GREEN_PERIOD` cycles. All-red between greens lasts exactly `CLEAR_PERIOD` cycles, plus any cycles spent blocked.
- `blocked` is sampled only at a grant decision, i.e. in IDLE, or in CLEAR at counter 0. Deasserting it yields green on the next cycle.
- A held `request` on the served way re-sets its `pending` bit the cycle after the grant. That way is then re-served in round-robin turn.
- Counter arithmetic is 32-bit unsigned. Parameter values are never exceeded, so there is no wrap.

## Configuration
- `GREEN_EXTEND_EN` defined: in GREEN at counter == 0, if `pending[sel]` or `request[sel]` is high and no other `pending` bit is set:
  - Stay in GREEN and reload counter with `GREEN_PERIOD-1`.
  - Clear `pending[sel]`; `ptr` is unchanged.
  - Green stays continuous with no clearance.
- `GREEN_EXTEND_EN` undefined: green always ends after `GREEN_PERIOD` cycles, per the GREEN state rules.

## Test plan
All scenarios use `N_WAYS=4`, `GREEN_PERIOD=5`, `CLEAR_PERIOD=2`, with cycle 0 the first cycle after reset release.
- One-cycle `request=4'b0100` in cycle 0:
  - `green=4'b0100` in cycles 2–6.
  - All red in cycles 7–8.
  - `busy=0` and IDLE in cycle 9.
- `request=4'b1111` pulsed in cycle 0: greens in order 0,1,2,3, each 5 cycles, with exactly 2 all-red cycles between them. `green` is never multi-hot.
- Fairness: after way 2 is served, pulse `request=4'b1010` in the same cycle → way 3 is green before way 1.
- Blocking:
  - `blocked=1` with `pending=4'b0001` in IDLE → `green=0` for 10 cycles.
  - Deassert `blocked` in cycle k → `green[0]=1` in cycle k+1.
  - `blocked=1` during GREEN → green still runs the full 5 cycles.
- Reset asserted in the third green cycle → next cycle `green=0`, `pending=0`, `busy=0`. A fresh request on way 3 is then served.
- With `GREEN_EXTEND_EN`:
  - `request[1]` held alone → `green[1]` continuous for 20+ cycles.
  - Then pulse `request[0]` → `green[1]` ends at the next counter expiry, followed by 2 red cycles, then `green[0]`.
